// File: rtl/pb_uart_7seg_core.sv
// UART loopback and 4-digit hex display core.
// A free-running transmitter sends an incrementing byte stream (8N1, LSB first).
// A receiver decodes uart_rx. The last good byte and a good-frame count are
// scanned in hex onto a multiplexed, active-low 7-segment display.
// Ports:
//   clk_50m  - system clock, rising edge
//   sw_rst_n - asynchronous active-low reset
//   uart_tx  - serial transmit line, idle high, registered
//   uart_rx  - serial receive line, asynchronous to clk_50m
//   leds_o   - segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   sels_o   - digit selects, active-low one-hot, bit0 = rightmost digit
module pb_uart_7seg_core #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned TX_GAP   = 1000,
  parameter int unsigned REFRESH  = 50_000
) (
  input  logic       clk_50m,
  input  logic       sw_rst_n,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic [7:0] leds_o,
  output logic [3:0] sels_o
);

  localparam int unsigned BIT_CYC  = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned GAP_LAST = (TX_GAP > 0) ? TX_GAP - 1 : 0;
  localparam int unsigned TX_MAX   = (BIT_CYC > TX_GAP) ? BIT_CYC : TX_GAP;
  localparam int unsigned TXC_W    = $clog2(TX_MAX + 1);
  localparam int unsigned RXC_W    = $clog2(BIT_CYC + 1);
  localparam int unsigned REF_W    = $clog2(REFRESH + 1);

  typedef enum logic [2:0] {
    TXS_IDLE, TXS_START, TXS_DATA, TXS_STOP, TXS_GAP
  } tx_state_e;

  typedef enum logic [1:0] {
    RXS_IDLE, RXS_START, RXS_DATA, RXS_STOP
  } rx_state_e;

  // Active-low {g..a} hex glyphs.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------- TX
  tx_state_e        tx_state_q;
  logic [TXC_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_byte_q;
  logic [7:0]       tx_shift_q;

  // Transmit FSM; uart_tx is driven straight from a flop so it cannot glitch.
  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      tx_state_q <= TXS_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_shift_q <= '0;
      uart_tx    <= 1'b1;
    end else begin
      case (tx_state_q)
        TXS_IDLE: begin
          tx_state_q <= TXS_START;
          tx_cnt_q   <= '0;
          uart_tx    <= 1'b0;
        end
        TXS_START: begin
          if (tx_cnt_q == TXC_W'(BIT_CYC - 1)) begin
            tx_state_q <= TXS_DATA;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            uart_tx    <= tx_byte_q[0];
            tx_shift_q <= tx_byte_q >> 1;
          end else begin
            tx_cnt_q <= tx_cnt_q + TXC_W'(1);
          end
        end
        TXS_DATA: begin
          if (tx_cnt_q == TXC_W'(BIT_CYC - 1)) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TXS_STOP;
              uart_tx    <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              uart_tx    <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + TXC_W'(1);
          end
        end
        TXS_STOP: begin
          if (tx_cnt_q == TXC_W'(BIT_CYC - 1)) begin
            tx_cnt_q <= '0;
            // With no gap configured the next start bit follows the stop bit directly.
            if (TX_GAP == 0) begin
              tx_state_q <= TXS_START;
              tx_byte_q  <= tx_byte_q + 8'd1;
              uart_tx    <= 1'b0;
            end else begin
              tx_state_q <= TXS_GAP;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + TXC_W'(1);
          end
        end
        TXS_GAP: begin
          if (tx_cnt_q == TXC_W'(GAP_LAST)) begin
            tx_state_q <= TXS_START;
            tx_cnt_q   <= '0;
            tx_byte_q  <= tx_byte_q + 8'd1;
            uart_tx    <= 1'b0;
          end else begin
            tx_cnt_q <= tx_cnt_q + TXC_W'(1);
          end
        end
        default: begin
          tx_state_q <= TXS_IDLE;
          uart_tx    <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  logic [1:0]       rx_sync_q;
  logic             rx_prev_q;
  logic             rx_s;
  rx_state_e        rx_state_q;
  logic [RXC_W-1:0] rx_cnt_cyc_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       rx_byte_q;
  logic [7:0]       rx_cnt_q;
  logic             ferr_q;

  assign rx_s = rx_sync_q[1];

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rx};
      rx_prev_q <= rx_s;
    end
  end

  // Receive FSM; a start needs a fresh 1->0 edge, so a line stuck low never re-triggers.
  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      rx_state_q   <= RXS_IDLE;
      rx_cnt_cyc_q <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_byte_q    <= '0;
      rx_cnt_q     <= '0;
      ferr_q       <= 1'b0;
    end else begin
      case (rx_state_q)
        RXS_IDLE: begin
          rx_cnt_cyc_q <= '0;
          if (rx_prev_q && !rx_s) begin
            rx_state_q <= RXS_START;
          end
        end
        RXS_START: begin
          if (rx_cnt_cyc_q == RXC_W'(HALF_CYC - 1)) begin
            rx_cnt_cyc_q <= '0;
            rx_bit_q     <= '0;
            // High at the start-bit centre means it was only a glitch.
            rx_state_q   <= rx_s ? RXS_IDLE : RXS_DATA;
          end else begin
            rx_cnt_cyc_q <= rx_cnt_cyc_q + RXC_W'(1);
          end
        end
        RXS_DATA: begin
          if (rx_cnt_cyc_q == RXC_W'(BIT_CYC - 1)) begin
            rx_cnt_cyc_q <= '0;
            rx_shift_q   <= {rx_s, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RXS_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_cyc_q <= rx_cnt_cyc_q + RXC_W'(1);
          end
        end
        RXS_STOP: begin
          if (rx_cnt_cyc_q == RXC_W'(BIT_CYC - 1)) begin
            rx_cnt_cyc_q <= '0;
            rx_state_q   <= RXS_IDLE;
            if (rx_s) begin
              rx_byte_q <= rx_shift_q;
              rx_cnt_q  <= rx_cnt_q + 8'd1;
              ferr_q    <= 1'b0;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            rx_cnt_cyc_q <= rx_cnt_cyc_q + RXC_W'(1);
          end
        end
        default: rx_state_q <= RXS_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- display
  logic [REF_W-1:0] scan_cnt_q;
  logic [1:0]       scan_idx_q;
  logic             scan_step;
  logic [1:0]       scan_idx_d;
  logic [3:0]       nib_d;
  logic             dp_d;

  // Next digit and its contents, latched only on a scan step so selects and segments move together.
  always_comb begin
    scan_step  = (scan_cnt_q == REF_W'(REFRESH - 1));
    scan_idx_d = scan_step ? scan_idx_q + 2'd1 : scan_idx_q;
    case (scan_idx_d)
      2'd0:    nib_d = rx_byte_q[3:0];
      2'd1:    nib_d = rx_byte_q[7:4];
      2'd2:    nib_d = rx_cnt_q[3:0];
      default: nib_d = rx_cnt_q[7:4];
    endcase
    dp_d = ~((scan_idx_d == 2'd0) && ferr_q);
  end

  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      sels_o     <= 4'b1110;
      leds_o     <= 8'hC0;
    end else if (scan_step) begin
      scan_cnt_q <= '0;
      scan_idx_q <= scan_idx_d;
      sels_o     <= ~(4'b0001 << scan_idx_d);
      leds_o     <= {dp_d, hex_glyph(nib_d)};
    end else begin
      scan_cnt_q <= scan_cnt_q + REF_W'(1);
    end
  end

endmodule

// File: tb/tb_pb_uart_7seg_core.sv
// Self-checking bench for pb_uart_7seg_core.
// Two instances share clock and reset: u_dut (short gap, switchable RX source)
// and u_wrap (no gap, permanent loopback, runs past 256 frames).
// Scaled timing: 16 cycles per bit, refresh every 4 cycles.
module tb_pb_uart_7seg_core;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 62_500;
  localparam int unsigned B        = 16;
  localparam int unsigned GAP      = 20;
  localparam int unsigned R        = 4;
  localparam int unsigned P        = 10 * B + GAP;
  localparam int unsigned P2       = 10 * B;
  localparam int unsigned SETTLE   = 10 * B + R + 4;

  logic       clk;
  logic       rst_n;
  logic       tx_m, rx_m, tx_w;
  logic [7:0] leds_m, leds_w;
  logic [3:0] sels_m, sels_w;
  logic       loop_en, rx_drv;

  assign rx_m = loop_en ? tx_m : rx_drv;

  pb_uart_7seg_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TX_GAP(GAP), .REFRESH(R)) u_dut (
    .clk_50m(clk), .sw_rst_n(rst_n), .uart_tx(tx_m), .uart_rx(rx_m),
    .leds_o(leds_m), .sels_o(sels_m));

  pb_uart_7seg_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TX_GAP(0), .REFRESH(R)) u_wrap (
    .clk_50m(clk), .sw_rst_n(rst_n), .uart_tx(tx_w), .uart_rx(tx_w),
    .leds_o(leds_w), .sels_o(sels_w));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Edges since reset release; outputs after edge n are sampled on the following negedge.
  int unsigned n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_byte, m_cnt;
  logic       m_ferr, m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  function automatic logic [7:0] disp_exp(input int idx, input int byt, input int cnt, input bit ferr);
    int nib;
    case (idx)
      0:       nib = byt % 16;
      1:       nib = byt / 16;
      2:       nib = cnt % 16;
      default: nib = cnt / 16;
    endcase
    return {~(idx == 0 && ferr), glyph(nib)};
  endfunction

  // Line level after edge nn for a transmitter whose frame f carries byte f mod 256.
  function automatic logic tx_exp(input int unsigned nn, input int unsigned period);
    int unsigned p, f;
    if (nn == 0) return 1'b1;
    p = (nn - 1) % period;
    f = (nn - 1) / period;
    if (p < B)     return 1'b0;
    if (p < 9 * B) return 1'(((f % 256) >> ((p - B) / B)) & 1);
    return 1'b1;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int          idx;
    int unsigned c;
    logic [3:0]  s;
    idx = int'((n / R) % 4);
    s   = ~(4'b0001 << idx);
    check("tx_m", 32'(tx_m), 32'(tx_exp(n, P)));
    check("sels_m", 32'(sels_m), 32'(s));
    if (m_valid) check("leds_m", 32'(leds_m), 32'(disp_exp(idx, int'(m_byte), int'(m_cnt), m_ferr)));
    check("tx_w", 32'(tx_w), 32'(tx_exp(n, P2)));
    check("sels_w", 32'(sels_w), 32'(s));
    if (!(n >= 9 * B && ((n - 9 * B) % P2) < B + R + 4)) begin
      c = (n < SETTLE) ? 0 : (n - SETTLE) / P2 + 1;
      check("leds_w", 32'(leds_w),
            32'(disp_exp(idx, (c == 0) ? 0 : int'((c - 1) % 256), int'(c % 256), 1'b0)));
    end
  end

  task automatic wait_n(input int unsigned target);
    int guard = 0;
    while (n < target) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 90000) begin
        $display("FAIL wait_n: stuck at n=%0d waiting for %0d", n, target);
        $fatal(1);
      end
    end
  endtask

  task automatic check_digits(input bit wrap, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] ex [4];
    ex = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      int         t;
      logic [3:0] want, cur;
      t    = 0;
      want = ~(4'b0001 << i);
      @(negedge clk);
      cur = wrap ? sels_w : sels_m;
      while (cur != want && t < 12) begin
        @(negedge clk);
        cur = wrap ? sels_w : sels_m;
        t++;
      end
      if (cur != want) check($sformatf("scan_find%0d", i), 32'(cur), 32'(want));
      else check($sformatf("%s_digit%0d", wrap ? "wrap" : "main", i),
                 32'(wrap ? leds_w : leds_m), 32'(ex[i]));
    end
  endtask

  // Drives one 8N1 frame on the manual RX line and updates the model once it has settled.
  task automatic send_frame(input logic [7:0] byt, input bit stop);
    logic [9:0] bits;
    bits = {stop, byt, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      if (i == 9) m_valid = 1'b0;
      repeat (B) begin @(posedge clk); #1; end
    end
    rx_drv = 1'b1;
    repeat (R + 4) begin @(posedge clk); #1; end
    if (stop) begin
      m_byte = byt;
      m_cnt  = m_cnt + 8'd1;
      m_ferr = 1'b0;
    end else begin
      m_ferr = 1'b1;
    end
    m_valid = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
  endtask

  logic [3:0] scan_sels [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] scan_leds [4] = '{8'hC6, 8'hB0, 8'hF9, 8'hC0};

  initial begin
    #300_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    loop_en = 1'b1; rx_drv = 1'b1;
    m_byte = '0; m_cnt = '0; m_ferr = 1'b0; m_valid = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_tx", 32'(tx_m), 32'd1);
    check("rst_sels", 32'(sels_m), 32'(4'b1110));
    check("rst_leds", 32'(leds_m), 32'h0000_00C0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("tx_fall", 32'(tx_m), 32'd0);

    // Loopback: frames 0x00 and 0x01
    for (int k = 0; k < 2; k++) begin
      wait_n(k * P + 9 * B);
      m_valid = 1'b0;
      wait_n(k * P + SETTLE);
      m_byte = 8'(k); m_cnt = 8'(k + 1); m_valid = 1'b1;
      if (k == 0) begin
        wait_n(P);
        check("gap_high", 32'(tx_m), 32'd1);
        wait_n(P + 1);
        check("start1", 32'(tx_m), 32'd0);
        wait_n(P + 1 + B);
        check("f1_bit0", 32'(tx_m), 32'd1);
      end
    end
    wait_n(350);
    loop_en = 1'b0;
    wait_n(2 * P + 1);
    check("start2", 32'(tx_m), 32'd0);
    check_digits(1'b0, 8'hF9, 8'hC0, 8'hA4, 8'hC0);

    // Framing error then a good frame
    send_frame(8'h5A, 1'b0);
    check_digits(1'b0, 8'h79, 8'hC0, 8'hA4, 8'hC0);
    send_frame(8'hA5, 1'b1);
    check_digits(1'b0, 8'h92, 8'h88, 8'hB0, 8'hC0);

    // Glitch shorter than half a bit is ignored; receiver still takes the next frame
    @(posedge clk); #1;
    rx_drv = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rx_drv = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    check_digits(1'b0, 8'h92, 8'h88, 8'hB0, 8'hC0);
    send_frame(8'h3C, 1'b1);
    check_digits(1'b0, 8'hC6, 8'hB0, 8'h99, 8'hC0);

    // Wrap instance has received 256 frames: last byte 0xFF, count 0x00
    wait_n(41_000);
    check_digits(1'b1, 8'h8E, 8'h8E, 8'hC0, 8'hC0);

    // Reset in the middle of a start bit
    wait_n(228 * P + 6);
    check("pre_rst_tx", 32'(tx_m), 32'd0);
    rst_n = 1'b0;
    m_byte = '0; m_cnt = '0; m_ferr = 1'b0;
    #1;
    check("midrst_tx", 32'(tx_m), 32'd1);
    check("midrst_sels", 32'(sels_m), 32'(4'b1110));
    check("midrst_leds", 32'(leds_m), 32'h0000_00C0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("tx_fall2", 32'(tx_m), 32'd0);

    // Scan sequence with byte 0x3C, count 0x01
    send_frame(8'h3C, 1'b1);
    t = 0;
    @(negedge clk);
    while (sels_m != 4'b0111 && t < 20) begin @(negedge clk); t++; end
    t = 0;
    while (sels_m != 4'b1110 && t < 8) begin @(negedge clk); t++; end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("seq_sels%0d", i), 32'(sels_m), 32'(scan_sels[i]));
      check($sformatf("seq_leds%0d", i), 32'(leds_m), 32'(scan_leds[i]));
      repeat (R) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
